// File: rtl/fifo_reader_if.sv
// fifo_reader_if: upstream FIFO read port plus downstream valid/ready word stream
interface fifo_reader_if #(
    parameter int DATA_W = 8
);
    logic              fifo_empty_i;
    logic [DATA_W-1:0] fifo_data_i;
    logic              fifo_rd_en_o;
    logic              valid_o;
    logic [DATA_W-1:0] data_o;
    logic              ready_i;
    logic [15:0]       words_o;
    modport slave (
        input  fifo_empty_i, fifo_data_i, ready_i,
        output fifo_rd_en_o, valid_o, data_o, words_o
    );
    modport master (
        output fifo_empty_i, fifo_data_i, ready_i,
        input  fifo_rd_en_o, valid_o, data_o, words_o
    );
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader: drains an upstream FIFO (1-cycle read latency) into a 2-entry valid/ready output buffer.
// Define FIFO_READER_STATS_EN to make words_o a wrapping 16-bit count of delivered words.
module fifo_reader #(
    parameter int DATA_W = 8,
    parameter int ID     = 0
) (
    input logic          clk_i,
    input logic          rst_ni,
    fifo_reader_if.slave bus
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_e;
    occ_e              occ_q, occ_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic              valid, pop, capture, rd_en, empty_after_pop;
    logic [2:0]        credit;
    logic [31:0]       unused_id;
    assign unused_id       = 32'(ID);
    assign valid           = occ_q != EMPTY;
    assign pop             = valid && bus.ready_i;
    assign capture         = pend_q;
    assign credit          = {1'b0, occ_q} + {2'b0, pend_q} - {2'b0, pop};
    assign rd_en           = !bus.fifo_empty_i && rst_ni && credit < 3'd2;
    assign empty_after_pop = occ_q == EMPTY || (occ_q == ONE && pop);
    assign bus.fifo_rd_en_o = rd_en;
    assign bus.valid_o      = valid;
    assign bus.data_o       = head_q;
    // State register: occupancy, in-flight read flag and the two buffer entries
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            occ_q  <= EMPTY;
            pend_q <= 1'b0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            pend_q <= pend_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end
    // Next occupancy: up on a lone capture, down on a lone pop, else unchanged
    always_comb begin
        occ_d = occ_q;
        if (capture && !pop)
            occ_d = (occ_q == EMPTY) ? ONE : TWO;
        else if (pop && !capture)
            occ_d = (occ_q == TWO) ? ONE : EMPTY;
    end
    // Buffer datapath: tail advances to head on pop, captured word fills the first free slot after the pop
    always_comb begin
        pend_d = rd_en;
        head_d = (pop && occ_q == TWO) ? tail_q : head_q;
        tail_d = tail_q;
        if (capture && empty_after_pop)
            head_d = bus.fifo_data_i;
        else if (capture)
            tail_d = bus.fifo_data_i;
    end
`ifdef FIFO_READER_STATS_EN
    logic [15:0] words_q, words_d;
    assign words_d     = words_q + {15'd0, pop};
    assign bus.words_o = words_q;
    // Delivered-word counter, wraps at 16 bits
    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            words_q <= '0;
        else
            words_q <= words_d;
    end
`else
    assign bus.words_o = 16'd0;
`endif
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed vector table plus random traffic against a queue-based upstream FIFO and order scoreboard
module tb_fifo_reader;
`ifdef FIFO_READER_STATS_EN
    localparam logic [15:0] STATS_MASK = 16'hFFFF;
`else
    localparam logic [15:0] STATS_MASK = 16'h0000;
`endif
    typedef struct {
        logic       rstn;
        logic       rdy;
        logic       push;
        logic [7:0] pd;
        logic       ev;
        logic [7:0] ed;
        logic       erd;
        logic       cd;
    } vec_t;
    localparam int NV = 21;
    vec_t tv [NV];
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ready = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    int         held = 0;
    int         delivered = 0;
    int         cnt;
    logic       armed = 1'b0;
    logic       after_rst = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_d = 8'h00;
    logic       sv, srd;
    logic [7:0] sd;
    fifo_reader_if #(.DATA_W(8)) bus ();
    assign bus.fifo_empty_i = fifo_empty;
    assign bus.fifo_data_i  = fifo_data;
    assign bus.ready_i      = ready;
    fifo_reader #(.DATA_W(8), .ID(0)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask
    task step(input logic rstn, input logic rdy, input logic push, input logic [7:0] pd);
        logic p;
        @(negedge clk);
        rst_n = rstn;
        ready = rdy;
        if (push) begin
            fq.push_back(pd);
            exp_q.push_back(pd);
        end
        fifo_empty = (fq.size() == 0);
        #1;
        sv  = bus.valid_o;
        sd  = bus.data_o;
        srd = bus.fifo_rd_en_o;
        p   = sv && rdy;
        if (!rstn) chk("rd_en_in_reset", srd, 0);
        else if (armed) begin
            chk("underflow", srd && fifo_empty, 0);
            chk("credit", (held + int'(srd) - int'(p)) <= 2, 1);
            chk("words", bus.words_o, 16'(delivered) & STATS_MASK);
            if (after_rst) begin
                chk("post_reset_valid", sv, 0);
                chk("post_reset_data", sd, 0);
            end
            if (prev_stall) begin
                chk("stall_valid", sv, 1);
                chk("stall_data", sd, prev_d);
            end
            if (p) begin
                chk("word_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("order", sd, exp_q.pop_front());
            end
        end
        @(posedge clk);
        if (!rstn) begin
            fq.delete();
            exp_q.delete();
            held       = 0;
            delivered  = 0;
            prev_stall = 1'b0;
            armed      = 1'b1;
            after_rst  = 1'b1;
        end else begin
            if (srd && fq.size() > 0) fifo_data <= fq.pop_front();
            held       = held + int'(srd) - int'(p);
            delivered  = delivered + int'(p);
            prev_stall = sv && !rdy;
            prev_d     = sd;
            after_rst  = 1'b0;
        end
    endtask
    initial begin
        tv[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
        tv[1]  = '{1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b1};
        tv[2]  = '{1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 1'b1};
        tv[3]  = '{1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 8'h11, 1'b1, 1'b0};
        tv[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b0};
        tv[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b0};
        tv[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[7]  = '{1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[8]  = '{1'b1, 1'b0, 1'b1, 8'h66, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[9]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0, 1'b0};
        tv[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h66, 1'b0, 1'b0};
        tv[11] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h66, 1'b0, 1'b0};
        tv[12] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[13] = '{1'b1, 1'b0, 1'b1, 8'h77, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[14] = '{1'b1, 1'b0, 1'b1, 8'h78, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[15] = '{1'b0, 1'b0, 1'b1, 8'h79, 1'b1, 8'h77, 1'b0, 1'b0};
        tv[16] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
        tv[17] = '{1'b1, 1'b1, 1'b1, 8'h9A, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[18] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[19] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h9A, 1'b0, 1'b0};
        tv[20] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < NV; i++) begin
            step(tv[i].rstn, tv[i].rdy, tv[i].push, tv[i].pd);
            chk($sformatf("tv%0d_valid", i), sv, tv[i].ev);
            chk($sformatf("tv%0d_rd_en", i), srd, tv[i].erd);
            if (tv[i].ev || tv[i].cd) chk($sformatf("tv%0d_data", i), sd, tv[i].ed);
        end
        for (int k = 0; k < 4; k++) begin
            fq.push_back(8'hA0 + 8'(k));
            exp_q.push_back(8'hA0 + 8'(k));
        end
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            cnt += int'(srd);
        end
        chk("bp_rd_pulses", cnt, 2);
        chk("bp_valid", sv, 1);
        chk("bp_data", sd, 8'hA0);
        got.delete();
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b1, 1'b0, 8'h00);
            if (sv) got.push_back(sd);
        end
        chk("bp_count", got.size(), 4);
        for (int k = 0; k < 4 && k < got.size(); k++)
            chk($sformatf("bp_word%0d", k), got[k], 8'hA0 + 8'(k));
        for (int k = 0; k < 20; k++) begin
            step(1'b1, k[0], 1'b0, 8'h00);
            chk("empty_guard_rd", srd, 0);
        end
        for (int k = 0; k < 3000; k++)
            step($urandom_range(0, 299) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 4, 8'($urandom));
        for (int k = 0; k < 500 && exp_q.size() > 0; k++)
            step(1'b1, 1'b1, 1'b0, 8'h00);
        chk("drain", exp_q.size(), 0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 65537; k++)
            step(1'b1, 1'b1, 1'b1, 8'(k));
        for (int k = 0; k < 4; k++)
            step(1'b1, 1'b1, 1'b0, 8'h00);
        chk("wrap_delivered", delivered, 65537);
        @(negedge clk);
        #1;
        chk("wrap_words", bus.words_o, 16'd1 & STATS_MASK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits; matches the upstream circ_fifo DATA_W.
REQ-002 Parameter ID, default 0, instance tag for debug prints only; no functional effect.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset, synchronous, active-low.
REQ-005 fifo_empty_i  input  1  upstream FIFO empty flag.
REQ-006 fifo_data_i  input  DATA_W  upstream FIFO read data, valid the cycle after fifo_rd_en_o is high.
REQ-007 fifo_rd_en_o  output  1  pop request to upstream FIFO.
REQ-008 valid_o  output  1  output word available.
REQ-009 data_o  output  DATA_W  output word.
REQ-010 ready_i  input  1  consumer accepts data_o when valid_o is also high.
REQ-011 words_o  output  16  delivered-word count; see Configuration.

Function
REQ-012 The block SHALL hold a 2-entry output buffer (head, tail); head drives data_o; valid_o = occupancy != 0.
REQ-013 Occupancy states SHALL be EMPTY(0), ONE(1), TWO(2); transitions: +1 on capture only, -1 on pop only, unchanged on capture and pop together or on neither.
REQ-014 pop = valid_o && ready_i; capture = pend_q, where pend_q is a register set to fifo_rd_en_o each cycle.
REQ-015 fifo_rd_en_o SHALL be combinational: !fifo_empty_i && rst_ni && (occupancy + pend_q - pop) < 2.
REQ-016 fifo_rd_en_o SHALL never assert while fifo_empty_i is high, so the upstream underflow flag never sets.
REQ-017 On capture, fifo_data_i SHALL be written to head if the buffer is empty after pop, else to tail; on pop with tail valid, tail SHALL move to head in the same cycle.
REQ-018 Output order SHALL equal FIFO read order; no word is duplicated or dropped.
REQ-019 While valid_o && !ready_i, data_o and valid_o SHALL hold stable.
REQ-020 With the FIFO non-empty and ready_i held high, the block SHALL sustain one word per cycle after a first-word latency of 2 cycles from fifo_empty_i falling (rd_en cycle, capture cycle, valid_o next).
REQ-021 Capture with occupancy TWO and no pop SHALL be unreachable; the credit rule in REQ-015 guarantees this.

Reset
REQ-022 When rst_ni is low at a rising clk_i edge: occupancy = EMPTY, pend_q = 0, head = tail = 0, words counter = 0.
REQ-023 Reset values: valid_o = 0, data_o = 0, fifo_rd_en_o = 0 (forced low combinationally while rst_ni is low), words_o = 0.
REQ-024 A word in flight (pend_q high) at reset SHALL be discarded; the upstream FIFO resets on the same signal.

Configuration
REQ-025 Macro FIFO_READER_STATS_EN: when defined, words_o SHALL count pops (+1 per pop, wrapping 16'hFFFF to 0, reset to 0).
REQ-026 When FIFO_READER_STATS_EN is undefined, words_o SHALL be tied to 0 and no counter logic SHALL be synthesized; the port SHALL remain present.

Verification
REQ-027 Reset mid-stream: occupancy TWO, pend_q=1, rst_ni low for 1 cycle -> valid_o=0, data_o=0, fifo_rd_en_o=0 next cycle; first word after reset is the next FIFO entry.
REQ-028 Streaming: FIFO preloaded 0x11,0x22,0x33, ready_i=1 -> valid_o high 3 consecutive cycles with data_o 0x11,0x22,0x33, then valid_o=0; words_o=3 with FIFO_READER_STATS_EN.
REQ-029 Backpressure: ready_i=0 with FIFO holding 0xA0..0xA3 -> fifo_rd_en_o pulses exactly twice; valid_o=1, data_o=0xA0 stable; after ready_i=1, data_o = A0,A1,A2,A3 in order.
REQ-030 Empty guard: fifo_empty_i=1 for 20 cycles with ready_i toggling -> fifo_rd_en_o=0 throughout; upstream underflow_o stays 0.
REQ-031 Simultaneous capture and pop at occupancy ONE: head=0x55 popped while 0x66 captured -> occupancy stays ONE, data_o=0x66 next cycle.
REQ-032 Counter wrap: with FIFO_READER_STATS_EN, 65537 pops -> words_o=1; without the macro, words_o=0 throughout.
